fifo_wr_arbiter: RTL and testbench

- Shares one sync_fifo_spram write port among NREQ producers.
- Uses round-robin arbitration with packet lock: a granted requester keeps the port until it sends its last beat or hits the beat limit.
- Sits directly in front of the FIFO and drives its wr/din.
- Never writes while the FIFO reports full, so the FIFO's used_cnt stays exact.

---
 rtl/fifo_pkg.sv | 40 ++++
 rtl/rr_pick_onehot.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: arbiter state encoding,
// FIFO width/count localparams and the round-robin pick helper.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_AW + 1;

  // Widest requester set any scheduler in this slice supports.
  localparam int RR_MAXN    = 8;

  // First set bit of valid searching upward from ptr, wrapping at nreq.
  // Returns ptr when nothing is valid; callers qualify with their own found flag.
  function automatic int rr_pick(input logic [RR_MAXN-1:0] valid,
                                 input int ptr,
                                 input int nreq);
    int   pick;
    int   c;
    logic hit;
    pick = ptr;
    hit  = 1'b0;
    for (int k = 0; k < RR_MAXN; k++) begin
      c = (ptr + k) % nreq;
      if ((k < nreq) && !hit && valid[c[2:0]]) begin
        pick = c;
        hit  = 1'b1;
      end else begin
        hit  = hit;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational round-robin picker: winner is the first valid index at or
// above ptr, modulo NREQ. Shared by write- and read-side schedulers.
module rr_pick_onehot
  import fifo_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [RR_MAXN-1:0] valid_ext_s;
  int                 pick_s;

  // Widen to the helper's fixed width and resolve the winner.
  always_comb begin
    valid_ext_s = RR_MAXN'(valid);
    pick_s      = rr_pick(valid_ext_s, int'(ptr), NREQ);
    found       = |valid;
    idx         = IDW'(pick_s);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among NREQ producers.
// Optional macro FIFO_WR_ARB_PRIO0_EN gives requester 0 strict priority when idle.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr,
  output logic [WIDTH-1:0]         fifo_din,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(MAX_BEATS) + 1;

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;

  logic [NREQ-1:0]   pick_valid_s;
  logic              pick_found_s;
  logic [IDW-1:0]    pick_idx_s;
  logic              prio_hit_s;
  logic              ptr_upd_s;

  logic              sel_valid_s;
  logic              sel_last_s;
  logic [WIDTH-1:0]  sel_data_s;
  logic              release_s;

`ifdef FIFO_WR_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign pick_valid_s = {req_valid[NREQ-1:1], 1'b0};
  assign prio_hit_s   = req_valid[0];
  assign ptr_upd_s    = (grant_id_q != '0);
`else
  assign pick_valid_s = req_valid;
  assign prio_hit_s   = 1'b0;
  assign ptr_upd_s    = 1'b1;
`endif

  rr_pick_onehot #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid (pick_valid_s),
    .ptr   (rr_ptr_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Route the current owner's valid/last/data through an AND-OR mux.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_valid_s = sel_valid_s | (req_valid[i] & (grant_id_q == IDW'(i)));
      sel_last_s  = sel_last_s  | (req_last[i]  & (grant_id_q == IDW'(i)));
      sel_data_s  = sel_data_s  |
                    (req_data[i*WIDTH +: WIDTH] & {WIDTH{grant_id_q == IDW'(i)}});
    end
  end

  // Next-state and port outputs; a stall on fifo_full holds everything.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    busy       = 1'b0;
    fifo_wr    = 1'b0;
    fifo_din   = '0;
    req_ready  = '0;
    release_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (prio_hit_s) begin
          grant_id_d = '0;
          state_d    = ST_XFER;
        end else if (pick_found_s) begin
          grant_id_d = pick_idx_s;
          state_d    = ST_XFER;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_XFER: begin
        busy     = 1'b1;
        fifo_din = sel_data_s;
        fifo_wr  = sel_valid_s & ~fifo_full;
        for (int i = 0; i < NREQ; i++) begin
          req_ready[i] = fifo_wr & (grant_id_q == IDW'(i));
        end
        release_s = fifo_wr & (sel_last_s | (beat_cnt_q == BW'(MAX_BEATS - 1)));
        if (release_s) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
          if (ptr_upd_s) begin
            rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
        end else if (fifo_wr) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized
// run against a beat-order reference model and a small FIFO model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int MAXB  = 4;
  localparam int DEPTH = 8;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_wr;
  logic [W-1:0]      fifo_din;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(W), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // producer sources, FIFO model and logs
  logic [7:0] src_d [NREQ][$];
  logic       src_l [NREQ][$];
  logic [7:0] fifo_q [$];
  logic [7:0] act_log [$];
  logic [7:0] exp_log [$];
  int         max_used;

  // reference model: current owner (-1 = none), rotation pointer, beats this grant
  int m_owner;
  int m_ptr;
  int m_beats;
  int cyc_bad;

  logic       obs_busy;
  logic       obs_wr;
  logic [3:0] obs_ready;
  logic [1:0] obs_grant;

  function automatic int model_pick(input logic [3:0] v, input int ptr);
    int c;
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (ptr + k) % NREQ;
      if (c != 0 && v[c]) return c;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      c = (ptr + k) % NREQ;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (src_d[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      src_d[r].push_back(base + 8'(k));
      src_l[r].push_back(k == n - 1);
    end
  endtask

  task automatic clear_state();
    for (int i = 0; i < NREQ; i++) begin
      src_d[i].delete();
      src_l[i].delete();
    end
    fifo_q.delete();
    act_log.delete();
    exp_log.delete();
    m_owner = -1; m_ptr = 0; m_beats = 0; cyc_bad = 0; max_used = 0;
    req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    clear_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive producer heads, compare against the model, update FIFO model.
  task automatic step(input logic [3:0] en, input logic rd);
    logic [3:0] v;
    logic       exp_wr;
    logic       lst;
    int         o;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      v[i] = en[i] && (src_d[i].size() > 0);
      req_valid[i] = v[i];
      req_data[i*W +: W] = v[i] ? src_d[i][0] : 8'h00;
      req_last[i] = v[i] ? src_l[i][0] : 1'b0;
    end
    #1;
    obs_busy = busy; obs_wr = fifo_wr; obs_ready = req_ready; obs_grant = grant_id;
    if (m_owner < 0) begin
      if (busy !== 1'b0 || fifo_wr !== 1'b0 || req_ready !== 4'b0000) cyc_bad++;
      m_owner = model_pick(v, m_ptr);
    end else begin
      o = m_owner;
      exp_wr = v[o] && !fifo_full;
      if (busy !== 1'b1 || grant_id !== 2'(o) || fifo_wr !== exp_wr) cyc_bad++;
      if (req_ready !== (exp_wr ? (4'b0001 << o) : 4'b0000)) cyc_bad++;
      if (exp_wr) begin
        if (fifo_din !== src_d[o][0]) cyc_bad++;
        exp_log.push_back(src_d[o][0]);
        lst = src_l[o][0];
        void'(src_d[o].pop_front());
        void'(src_l[o].pop_front());
        m_beats++;
        if (lst || m_beats == MAXB) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
          if (o != 0) m_ptr = (o + 1) % NREQ;
`else
          m_ptr = (o + 1) % NREQ;
`endif
          m_owner = -1;
          m_beats = 0;
        end
      end
    end
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (fifo_wr === 1'b1) begin
      act_log.push_back(fifo_din);
      fifo_q.push_back(fifo_din);
    end
    if (fifo_q.size() > max_used) max_used = fifo_q.size();
    @(posedge clk);
    #1;
    fifo_full = (fifo_q.size() >= DEPTH);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h44332211;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", fifo_wr); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    reset_all();
  endtask

  task automatic test_basic();
    logic [7:0] exp_ord [$];
    reset_all();
    add_pkt(0, 1, 8'h01);
    add_pkt(2, 1, 8'h21);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    checks++;
    if (obs_busy !== 1'b1 || obs_grant !== 2'd0 || obs_wr !== 1'b1)
      begin errors++; $display("FAIL basic_first_grant got busy=%b id=%0d wr=%b exp 1/0/1", obs_busy, obs_grant, obs_wr); end
    for (int c = 0; c < 20 && act_log.size() < 2; c++) step(4'b0101, 1'b0);
    for (int i = 0; i < NREQ; i++) add_pkt(i, 1, 8'h30 + 8'(i));
    for (int c = 0; c < 40 && act_log.size() < 6; c++) step(4'hF, 1'b0);
    exp_ord = '{8'h01, 8'h21, 8'h33, 8'h30, 8'h31, 8'h32};
    checks++; if (act_log.size() !== 6) begin errors++; $display("FAIL basic_count got %0d exp 6", act_log.size()); end
    for (int i = 0; i < exp_ord.size() && i < act_log.size(); i++) begin
      checks++; if (act_log[i] !== exp_ord[i]) begin errors++; $display("FAIL basic_order[%0d] got %h exp %h", i, act_log[i], exp_ord[i]); end
    end
    checks++; if (cyc_bad !== 0) begin errors++; $display("FAIL basic_cycles got %0d bad cycles exp 0", cyc_bad); end
  endtask

  task automatic test_lock();
    logic [7:0] exp_ord [$];
    reset_all();
    add_pkt(0, 1, 8'h01);
    for (int c = 0; c < 20 && act_log.size() < 1; c++) step(4'b0001, 1'b0);
    add_pkt(1, 3, 8'h11);
    add_pkt(2, 1, 8'h21);
    add_pkt(3, 1, 8'h31);
    add_pkt(0, 1, 8'h02);
    for (int c = 0; c < 60 && act_log.size() < 7; c++) step(4'hF, 1'b0);
    exp_ord = '{8'h01, 8'h11, 8'h12, 8'h13, 8'h21, 8'h31, 8'h02};
    checks++; if (act_log.size() !== 7) begin errors++; $display("FAIL lock_count got %0d exp 7", act_log.size()); end
    for (int i = 0; i < exp_ord.size() && i < act_log.size(); i++) begin
      checks++; if (act_log[i] !== exp_ord[i]) begin errors++; $display("FAIL lock_order[%0d] got %h exp %h", i, act_log[i], exp_ord[i]); end
    end
    checks++; if (cyc_bad !== 0) begin errors++; $display("FAIL lock_cycles got %0d bad cycles exp 0", cyc_bad); end
  endtask

  task automatic test_forced_release();
    logic [7:0] exp_ord [$];
    reset_all();
    add_pkt(2, 1, 8'h20);
    for (int c = 0; c < 20 && act_log.size() < 1; c++) step(4'b0100, 1'b0);
    add_pkt(3, 6, 8'h31);
    add_pkt(0, 1, 8'h01);
    for (int c = 0; c < 60 && act_log.size() < 8; c++) step(4'b1001, 1'b0);
    exp_ord = '{8'h20, 8'h31, 8'h32, 8'h33, 8'h34, 8'h01, 8'h35, 8'h36};
    checks++; if (act_log.size() !== 8) begin errors++; $display("FAIL forced_count got %0d exp 8", act_log.size()); end
    for (int i = 0; i < exp_ord.size() && i < act_log.size(); i++) begin
      checks++; if (act_log[i] !== exp_ord[i]) begin errors++; $display("FAIL forced_order[%0d] got %h exp %h", i, act_log[i], exp_ord[i]); end
    end
    checks++; if (cyc_bad !== 0) begin errors++; $display("FAIL forced_cycles got %0d bad cycles exp 0", cyc_bad); end
  endtask

  task automatic test_backpressure();
    reset_all();
    for (int i = 0; i < 7; i++) fifo_q.push_back(8'hEE);
    add_pkt(0, 3, 8'h01);
    repeat (8) step(4'b0001, 1'b0);
    checks++; if (act_log.size() !== 1) begin errors++; $display("FAIL bp_written got %0d exp 1", act_log.size()); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_full got %b exp 1", fifo_full); end
    checks++;
    if (obs_wr !== 1'b0 || obs_ready !== 4'b0000 || obs_busy !== 1'b1 || obs_grant !== 2'd0)
      begin errors++; $display("FAIL bp_stall got wr=%b rdy=%b busy=%b id=%0d exp 0/0000/1/0", obs_wr, obs_ready, obs_busy, obs_grant); end
    repeat (2) step(4'b0001, 1'b1);
    for (int c = 0; c < 20 && act_log.size() < 3; c++) step(4'b0001, 1'b0);
    checks++; if (act_log.size() !== 3) begin errors++; $display("FAIL bp_total got %0d exp 3", act_log.size()); end
    checks++; if (act_log.size() == 3 && act_log[2] !== 8'h03) begin errors++; $display("FAIL bp_last got %h exp 03", act_log[2]); end
    checks++; if (max_used !== DEPTH) begin errors++; $display("FAIL bp_max_used got %0d exp %0d", max_used, DEPTH); end
    checks++; if (cyc_bad !== 0) begin errors++; $display("FAIL bp_cycles got %0d bad cycles exp 0", cyc_bad); end
  endtask

  task automatic test_reset_mid();
    reset_all();
    add_pkt(1, 1, 8'h10);
    for (int c = 0; c < 20 && act_log.size() < 1; c++) step(4'b0010, 1'b0);
    add_pkt(1, 5, 8'h11);
    for (int c = 0; c < 20 && act_log.size() < 3; c++) step(4'b0010, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_wr !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0000)
      begin errors++; $display("FAIL mid_reset got busy=%b wr=%b id=%0d rdy=%b exp 0/0/0/0000", busy, fifo_wr, grant_id, req_ready); end
    clear_state();
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(1, 1, 8'h19);
    add_pkt(2, 1, 8'h29);
    for (int c = 0; c < 20 && act_log.size() < 2; c++) step(4'b0110, 1'b0);
    checks++; if (act_log.size() !== 2) begin errors++; $display("FAIL mid_restart_count got %0d exp 2", act_log.size()); end
    checks++; if (act_log.size() == 2 && (act_log[0] !== 8'h19 || act_log[1] !== 8'h29))
      begin errors++; $display("FAIL mid_restart_order got %h,%h exp 19,29", act_log[0], act_log[1]); end
    checks++; if (cyc_bad !== 0) begin errors++; $display("FAIL mid_cycles got %0d bad cycles exp 0", cyc_bad); end
  endtask

`ifdef FIFO_WR_ARB_PRIO0_EN
  task automatic test_prio0();
    logic [7:0] exp_ord [$];
    reset_all();
    for (int k = 0; k < 4; k++) add_pkt(0, 1, 8'h01 + 8'(k));
    add_pkt(2, 1, 8'h21);
    for (int c = 0; c < 40 && act_log.size() < 4; c++) step(4'b0101, 1'b1);
    for (int c = 0; c < 20 && act_log.size() < 5; c++) step(4'b0101, 1'b1);
    add_pkt(2, 4, 8'h31);
    repeat (3) step(4'b0100, 1'b1);
    add_pkt(0, 1, 8'h05);
    for (int c = 0; c < 40 && act_log.size() < 10; c++) step(4'b0101, 1'b1);
    exp_ord = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h21, 8'h31, 8'h32, 8'h33, 8'h34, 8'h05};
    checks++; if (act_log.size() !== 10) begin errors++; $display("FAIL prio_count got %0d exp 10", act_log.size()); end
    for (int i = 0; i < exp_ord.size() && i < act_log.size(); i++) begin
      checks++; if (act_log[i] !== exp_ord[i]) begin errors++; $display("FAIL prio_order[%0d] got %h exp %h", i, act_log[i], exp_ord[i]); end
    end
    checks++; if (cyc_bad !== 0) begin errors++; $display("FAIL prio_cycles got %0d bad cycles exp 0", cyc_bad); end
  endtask
`endif

  task automatic test_random();
    logic [3:0] en;
    int r;
    int n;
    reset_all();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(2) == 0) begin
        r = $urandom_range(NREQ - 1);
        n = $urandom_range(6, 1);
        if (src_d[r].size() < 10) begin
          for (int k = 0; k < n; k++) begin
            src_d[r].push_back(8'($urandom));
            src_l[r].push_back(k == n - 1);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) en[i] = ($urandom_range(3) != 0);
      step(en, 1'($urandom_range(1)));
    end
    for (int c = 0; c < 3000 && !all_empty(); c++) step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    checks++; if (!all_empty()) begin errors++; $display("FAIL rand_drain got sources pending exp empty"); end
    checks++; if (act_log.size() !== exp_log.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", act_log.size(), exp_log.size()); end
    for (int i = 0; i < exp_log.size() && i < act_log.size(); i++) begin
      checks++; if (act_log[i] !== exp_log[i]) begin errors++; $display("FAIL rand_order[%0d] got %h exp %h", i, act_log[i], exp_log[i]); end
    end
    checks++; if (max_used > DEPTH) begin errors++; $display("FAIL rand_overflow got %0d exp <= %0d", max_used, DEPTH); end
    checks++; if (cyc_bad !== 0) begin errors++; $display("FAIL rand_cycles got %0d bad cycles exp 0", cyc_bad); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_state();
    test_reset();
`ifdef FIFO_WR_ARB_PRIO0_EN
    test_backpressure();
    test_prio0();
`else
    test_basic();
    test_lock();
    test_forced_release();
    test_backpressure();
    test_reset_mid();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
